bcd_7seg_scan: RTL and testbench

- Downstream consumer of the 4-bit binary-to-BCD converter (bb_dig): takes its 5-bit BCD result (tens bit B4, units nibble B3..B0) and drives a two-digit multiplexed seven-segment display.
- Captures the value on a load strobe and alternates digit enables with a programmable dwell time.
- Inserts blanking dead-time between digits to prevent ghosting.
- Supports optional leading-zero blanking; flags an out-of-range units nibble.

---
 rtl/bcd_disp_pkg.sv | 40 ++++
 rtl/bcd_seg_dec.sv | 13 +
 rtl/bcd_7seg_scan.sv | 128 ++++++++++++
 tb/tb_bcd_7seg_scan.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared definitions for the two-digit BCD seven-segment scanner: scan states,
// active-high segment patterns and the nibble decoder function.
package bcd_disp_pkg;

  typedef enum logic [1:0] {S_UNITS, S_GAP0, S_TENS, S_GAP1} scan_state_e;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_OFF = 7'h00;

  // Non-decimal nibbles show 'E'.
  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    logic [6:0] pattern;
    case (nibble)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_E;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/bcd_seg_dec.sv
// Combinational nibble to seven-segment decoder (active-high gfedcba).
module bcd_seg_dec
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = seg_decode(nibble);
  end

endmodule

// File: rtl/bcd_7seg_scan.sv
// Two-digit multiplexed seven-segment driver for a 5-bit BCD value, with
// frame-consistent capture, blanking dead-time and optional leading-zero blanking.
module bcd_7seg_scan
  import bcd_disp_pkg::*;
#(
  parameter int unsigned DIG_CYC        = 50000,
  parameter int unsigned GAP_CYC        = 500,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          LZ_BLANK       = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       B4,
  input  logic       B3,
  input  logic       B2,
  input  logic       B1,
  input  logic       B0,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       err
);

  localparam int unsigned MAX_CYC  = (DIG_CYC > GAP_CYC) ? DIG_CYC : GAP_CYC;
  localparam int unsigned CNT_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(DIG_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);

  // XOR masks applied at the register input turn active-high into pin polarity.
  localparam logic [6:0] SEG_MASK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0] AN_MASK  = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;
  localparam logic [1:0] AN_UNITS = 2'b01;
  localparam logic [1:0] AN_TENS  = 2'b10;

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       shadow_q;
  logic [4:0]       disp_q, disp_d;
  logic             err_q, err_d;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       an_q, an_d;
  logic [6:0]       units_seg, tens_seg;
  logic             terminal;

  assign terminal = (state_q inside {S_UNITS, S_TENS}) ? (cnt_q == DIG_LAST)
                                                       : (cnt_q == GAP_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    disp_d  = disp_q;
    err_d   = err_q;
    if (terminal) begin
      cnt_d = '0;
      unique case (state_q)
        S_UNITS: state_d = S_GAP0;
        S_GAP0:  state_d = S_TENS;
        S_TENS:  state_d = S_GAP1;
        S_GAP1: begin
          // Only frame boundary where the displayed value may change.
          state_d = S_UNITS;
          disp_d  = shadow_q;
          err_d   = (shadow_q[3:0] > 4'd9);
        end
        default: state_d = S_GAP1;
      endcase
    end
  end

  // Decode the next-state display value so outputs change on the same edge as the state.
  bcd_seg_dec u_units_dec (
    .nibble (disp_d[3:0]),
    .seg    (units_seg)
  );

  bcd_seg_dec u_tens_dec (
    .nibble ({3'b000, disp_d[4]}),
    .seg    (tens_seg)
  );

  always_comb begin
    seg_d = SEG_OFF;
    an_d  = 2'b00;
    unique case (state_d)
      S_UNITS: begin
        seg_d = units_seg;
        an_d  = AN_UNITS;
      end
      S_TENS: begin
        if (!(LZ_BLANK && !disp_d[4])) begin
          seg_d = tens_seg;
          an_d  = AN_TENS;
        end
      end
      default: begin
        seg_d = SEG_OFF;
        an_d  = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_GAP1;
      cnt_q    <= '0;
      shadow_q <= '0;
      disp_q   <= '0;
      err_q    <= 1'b0;
      seg_q    <= SEG_MASK;
      an_q     <= AN_MASK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      err_q   <= err_d;
      seg_q   <= seg_d ^ SEG_MASK;
      an_q    <= an_d ^ AN_MASK;
      if (load) begin
        shadow_q <= {B4, B3, B2, B1, B0};
      end
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign err = err_q;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Scoreboard bench for bcd_7seg_scan: a frame-timeline model predicts each cycle's
// pins, a negedge monitor pops and compares.
module tb_bcd_7seg_scan;

  localparam int unsigned DIG   = 4;
  localparam int unsigned GAP   = 1;
  localparam int unsigned FRAME = 2 * (DIG + GAP);

  localparam logic [6:0] DIGIT_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  typedef struct packed {
    logic [6:0] seg;
    logic [1:0] an;
    logic       err;
  } out_t;

  localparam out_t OFF_OUT = '{seg: 7'h7F, an: 2'b11, err: 1'b0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic       B4 = 1'b0, B3 = 1'b0, B2 = 1'b0, B1 = 1'b0, B0 = 1'b0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       err;

  int checks = 0;
  int errors = 0;

  out_t        exp_q[$];
  int unsigned t;
  int unsigned m_pos;
  logic [4:0]  m_shadow;
  logic [4:0]  m_disp;

  bcd_7seg_scan #(
    .DIG_CYC        (DIG),
    .GAP_CYC        (GAP),
    .SEG_ACTIVE_LOW (1'b1),
    .LZ_BLANK       (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .B4    (B4),
    .B3    (B3),
    .B2    (B2),
    .B1    (B1),
    .B0    (B0),
    .seg   (seg),
    .an    (an),
    .err   (err)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] digit_seg(input logic [3:0] n);
    if (n > 4'd9) return 7'h79;
    return DIGIT_TAB[n];
  endfunction

  // Pins expected while the frame sits at position pos showing value d.
  function automatic out_t expect_at(input int unsigned pos, input logic [4:0] d);
    out_t o;
    o = OFF_OUT;
    o.err = (d[3:0] > 4'd9);
    if (pos < DIG) begin
      o.an  = 2'b10;
      o.seg = ~digit_seg(d[3:0]);
    end else if (pos >= DIG + GAP && pos < 2 * DIG + GAP && d[4]) begin
      o.an  = 2'b01;
      o.seg = ~digit_seg(4'd1);
    end
    return o;
  endfunction

  task automatic chk(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got seg=%h an=%b err=%b, want seg=%h an=%b err=%b",
               name, $time, act.seg, act.an, act.err, exp.seg, exp.an, exp.err);
    end
  endtask

  // Reference model: edge t after reset release is position (t-1) mod FRAME.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t        = 0;
      m_shadow = '0;
      m_disp   = '0;
      exp_q.delete();
    end else begin
      t++;
      m_pos = (t - 1) % FRAME;
      if (m_pos == 0) m_disp = m_shadow;
      if (load) m_shadow = {B4, B3, B2, B1, B0};
      exp_q.push_back(expect_at(m_pos, m_disp));
    end
  end

  always @(negedge clk) begin
    out_t e;
    out_t a;
    a.seg = seg;
    a.an  = an;
    a.err = err;
    if (!rst_n || exp_q.size() == 0) e = OFF_OUT;
    else e = exp_q.pop_front();
    chk(rst_n ? "scan" : "in_reset", a, e);
    checks++;
    if (an === 2'b00) begin
      errors++;
      $display("FAIL both_anodes @%0t: got an=%b, want not 00", $time, an);
    end
  end

  task automatic set_b(input logic [4:0] v);
    {B4, B3, B2, B1, B0} = v;
  endtask

  task automatic do_load(input logic [4:0] v);
    @(posedge clk);
    #2;
    load = 1'b1;
    set_b(v);
    @(posedge clk);
    #2;
    load = 1'b0;
    set_b(5'($urandom_range(0, 31)));
  endtask

  // Leave the bench at 2 units after the edge that enters frame position p.
  task automatic wait_pos(input int unsigned p);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (((t - 1) % FRAME) != p && n < 4 * FRAME);
    if (n >= 4 * FRAME) begin
      checks++;
      errors++;
      $display("FAIL wait_pos: got no position %0d, want it within %0d cycles", p, 4 * FRAME);
    end
  endtask

  task automatic frames(input int n);
    repeat (n * FRAME) @(posedge clk);
    #2;
  endtask

  initial begin
    out_t a;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    frames(2);

    do_load(5'b10101);
    frames(2);

    wait_pos(DIG + GAP + 1);
    load = 1'b1;
    set_b(5'b00111);
    @(posedge clk);
    #2;
    load = 1'b0;
    frames(2);

    do_load(5'b01100);
    frames(2);
    do_load(5'b00011);
    frames(2);

    // Load on the exact frame-boundary edge must not reach this frame.
    do_load(5'b00010);
    wait_pos(FRAME - 1);
    load = 1'b1;
    set_b(5'b10000);
    @(posedge clk);
    #2;
    load = 1'b0;
    frames(2);

    wait_pos(1);
    rst_n = 1'b0;
    #1;
    a.seg = seg;
    a.an  = an;
    a.err = err;
    chk("async_blank", a, OFF_OUT);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    frames(2);

    repeat (40) begin
      repeat ($urandom_range(0, 12)) @(posedge clk);
      do_load(5'($urandom_range(0, 31)));
    end
    frames(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
